// File: rtl/pipe_pkg.sv
// Opcode encodings and IR field bounds shared by the decode, execute and memory stages.
package pipe_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    typedef logic [OP_HI-OP_LO:0] opcode_t;

    localparam opcode_t OP_NOP    = 6'h00;
    localparam opcode_t OP_ALU_LO = 6'h01;
    localparam opcode_t OP_ALU_HI = 6'h06;
    localparam opcode_t OP_LW     = 6'h08;
    localparam opcode_t OP_SW     = 6'h09;
    localparam opcode_t OP_BRANCH = 6'h0A;
    localparam opcode_t OP_J      = 6'h0B;

    function automatic logic is_alu(input opcode_t op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Private data memory: async clear, synchronous write, one registered read port
// (read data is zero when no read is requested), one combinational debug port.
module data_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [31:0]       dbg_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            rdata_q <= re_i ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o    = rdata_q;
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: loads/stores, branch/jump redirect, MEM/WB latch, retire counter.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned LW/SW and flags them on MEM_WB_Err.
module mem_access
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       EX_MEM_IR,
    input  logic [31:0]       EX_MEM_ALU_output,
    input  logic [31:0]       EX_MEM_B,
    input  logic              EX_MEM_Cond,
    output logic [31:0]       MEM_WB_IR,
    output logic [31:0]       MEM_WB_ALU_output,
    output logic [31:0]       MEM_WB_LMD,
    output logic              MEM_Branch_taken,
    output logic [31:0]       MEM_Branch_target,
    output logic [CNT_W-1:0]  MEM_Retired,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              MEM_WB_Err
`endif
);

    opcode_t           opcode;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              mem_we;
    logic              mem_re;

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      alu_q, alu_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    assign opcode   = EX_MEM_IR[OP_HI:OP_LO];
    // Upper address bits are dropped, so accesses wrap around the memory.
    assign word_idx = EX_MEM_ALU_output[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign misaligned = ((opcode == OP_LW) || (opcode == OP_SW)) && (EX_MEM_ALU_output[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_we = (opcode == OP_SW) && !misaligned;
    assign mem_re = (opcode == OP_LW) && !misaligned;

    data_mem #(.ADDR_W(ADDR_W)) u_dmem (
        .clk        (clk),
        .rst        (rst),
        .we_i       (mem_we),
        .re_i       (mem_re),
        .addr_i     (word_idx),
        .wdata_i    (EX_MEM_B),
        .rdata_o    (MEM_WB_LMD),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        ir_d      = EX_MEM_IR;
        alu_d     = EX_MEM_ALU_output;
        retired_d = (opcode != OP_NOP) ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q      <= '0;
            alu_q     <= '0;
            retired_q <= '0;
        end else begin
            ir_q      <= ir_d;
            alu_q     <= alu_d;
            retired_q <= retired_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign err_d = misaligned;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign MEM_WB_Err = err_q;
`endif

    assign MEM_Branch_taken  = ((opcode == OP_BRANCH) && EX_MEM_Cond) || (opcode == OP_J);
    assign MEM_Branch_target = EX_MEM_ALU_output;

    assign MEM_WB_IR         = ir_q;
    assign MEM_WB_ALU_output = alu_q;
    assign MEM_Retired       = retired_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a reference memory/counter model feeds a queue of expected
// MEM/WB values that is popped one cycle after each instruction is driven.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_ir, ex_alu, ex_b;
    logic        ex_cond;
    logic [31:0] wb_ir, wb_alu, wb_lmd;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] retired;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        wb_err;
`endif

    typedef struct {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    logic [31:0] model_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(8), .CNT_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM_IR         (ex_ir),
        .EX_MEM_ALU_output (ex_alu),
        .EX_MEM_B          (ex_b),
        .EX_MEM_Cond       (ex_cond),
        .MEM_WB_IR         (wb_ir),
        .MEM_WB_ALU_output (wb_alu),
        .MEM_WB_LMD        (wb_lmd),
        .MEM_Branch_taken  (br_taken),
        .MEM_Branch_target (br_target),
        .MEM_Retired       (retired),
        .dbg_addr          (dbg_addr),
        .dbg_data          (dbg_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MEM_WB_Err        (wb_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [5:0] op);
        return {op, 26'h0001234};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_cnt = '0;
        sb.delete();
    endtask

    // Drive one instruction, check branch outputs combinationally, then check MEM/WB after the edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] alu,
                        input logic [31:0] b, input logic cond);
        exp_t e;
        logic mis;
        logic [7:0] idx;
        ex_ir = mk_ir(op); ex_alu = alu; ex_b = b; ex_cond = cond;
        #1;
        chk({tag, "_taken"}, {31'b0, br_taken}, {31'b0, ((op == 6'h0A) && cond) || (op == 6'h0B)});
        if (br_taken) chk({tag, "_target"}, br_target, alu);
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((op == 6'h08) || (op == 6'h09)) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idx = alu[9:2];
        e.ir  = mk_ir(op);
        e.alu = alu;
        e.lmd = ((op == 6'h08) && !mis) ? model_mem[idx] : 32'h0;
        e.err = mis;
        sb.push_back(e);
        if ((op == 6'h09) && !mis) model_mem[idx] = b;
        if (op != 6'h00) model_cnt++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ir"}, wb_ir, e.ir);
            chk({tag, "_alu"}, wb_alu, e.alu);
            chk({tag, "_lmd"}, wb_lmd, e.lmd);
            chk({tag, "_retired"}, retired, model_cnt);
`ifdef MEM_ALIGN_CHECK_EN
            chk({tag, "_err"}, {31'b0, wb_err}, {31'b0, e.err});
`endif
        end
    endtask

    task automatic dbg(input string tag, input logic [7:0] a);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, model_mem[a]);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ir"}, wb_ir, 32'h0);
        chk({tag, "_alu"}, wb_alu, 32'h0);
        chk({tag, "_lmd"}, wb_lmd, 32'h0);
        chk({tag, "_retired"}, retired, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, "_err"}, {31'b0, wb_err}, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1; ex_ir = '0; ex_alu = '0; ex_b = '0; ex_cond = 1'b0; dbg_addr = '0;
        model_reset();
        #12;
        chk_reset_state("por");
        dbg("por_dbg0", 8'd0);
        rst = 1'b0;

        // Retire counter and IR trailing by one cycle
        step("c_nop0", 6'h00, 32'h0, 32'h0, 1'b0);
        step("c_alu",  6'h03, 32'h0000_1111, 32'h0, 1'b0);
        step("c_lw",   6'h08, 32'h0, 32'h0, 1'b0);
        step("c_nop1", 6'h00, 32'h0, 32'h0, 1'b0);
        step("c_sw",   6'h09, 32'h4, 32'h1234_5678, 1'b0);
        chk("cnt_is_3", retired, 32'd3);

        // Store then load
        step("sw8", 6'h09, 32'd8, 32'hDEAD_BEEF, 1'b0);
        step("lw8", 6'h08, 32'd8, 32'h0, 1'b0);
        chk("lw8_value", wb_lmd, 32'hDEAD_BEEF);
        dbg("dbg2", 8'd2);
        step("lw4", 6'h08, 32'd4, 32'h0, 1'b0);

        // Address wrap-around
        step("sw_wrap", 6'h09, 32'h0000_0404, 32'd7, 1'b0);
        dbg("dbg_wrap1", 8'd1);
        chk("wrap_value", dbg_data, 32'd7);

        // Branch / jump redirect
        step("br_t",    6'h0A, 32'h40, 32'h0, 1'b1);
        step("br_nt",   6'h0A, 32'h80, 32'h0, 1'b0);
        step("j",       6'h0B, 32'hC0, 32'h0, 1'b0);
        step("alu_c1",  6'h01, 32'h44, 32'h0, 1'b1);
        step("oth_c1",  6'h3F, 32'h48, 32'h0, 1'b1);

        // Misaligned store, then aligned load of the same word
        step("sw_mis", 6'h09, 32'd5, 32'd9, 1'b0);
        dbg("dbg_mis1", 8'd1);
        step("lw_mis", 6'h08, 32'd6, 32'h0, 1'b0);
        step("lw_1",   6'h08, 32'd4, 32'h0, 1'b0);

        // Asynchronous reset mid-cycle, with a store held across the reset edge
        #3;
        rst = 1'b1;
        ex_ir = mk_ir(6'h09); ex_alu = 32'd12; ex_b = 32'h55;
        #1;
        model_reset();
        chk_reset_state("arst");
        @(posedge clk);
        #1;
        chk_reset_state("arst_edge");
        dbg("arst_dbg1", 8'd1);
        dbg("arst_dbg2", 8'd2);
        dbg("arst_dbg3", 8'd3);
        rst = 1'b0;

        step("post_lw8", 6'h08, 32'd8, 32'h0, 1'b0);
        step("post_sw",  6'h09, 32'd16, 32'hA5A5_0001, 1'b0);
        step("post_lw",  6'h08, 32'd16, 32'h0, 1'b0);
        dbg("post_dbg4", 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the EX/MEM latch (instruction, ALU result, store data, branch condition), performs word loads and stores against a private data memory, resolves branch and jump redirection, and registers the MEM/WB latch for write-back. It also counts retired non-NOP instructions for debug.

## Interface
Parameters:
- ADDR_W, 8, word-index width; memory depth is 2^ADDR_W 32-bit words
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- EX_MEM_IR  in  32  instruction from execute
- EX_MEM_ALU_output  in  32  ALU result: byte address for LW/SW, target for branch/jump
- EX_MEM_B  in  32  store data
- EX_MEM_Cond  in  1  branch condition from execute
- MEM_WB_IR  out  32  registered instruction
- MEM_WB_ALU_output  out  32  registered ALU result
- MEM_WB_LMD  out  32  registered load data
- MEM_Branch_taken  out  1  combinational PC redirect request
- MEM_Branch_target  out  32  combinational redirect target
- MEM_Retired  out  CNT_W  count of non-NOP instructions passed through
- dbg_addr  in  ADDR_W  debug word index
- dbg_data  out  32  combinational memory read at dbg_addr
- MEM_WB_Err  out  1  misalignment flag (present only with MEM_ALIGN_CHECK_EN)

## Operation
- Opcode = IR[31:26]. 6'b000000 NOP; 6'b000001–6'b000110 ALU ops (pass-through); 6'b001000 LW; 6'b001001 SW; 6'b001010 BRANCH; 6'b001011 J. Other opcodes are treated as ALU pass-through.
- Word index = EX_MEM_ALU_output[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Every clock edge: MEM_WB_IR <= EX_MEM_IR; MEM_WB_ALU_output <= EX_MEM_ALU_output.
- LW: MEM_WB_LMD <= mem[index]. Any other opcode: MEM_WB_LMD <= 0.
- SW: mem[index] <= EX_MEM_B. No other opcode writes memory.
- MEM_Branch_taken = (BRANCH && EX_MEM_Cond) || J. MEM_Branch_target = EX_MEM_ALU_output, valid whenever taken. For non-branch opcodes, MEM_Branch_taken is 0 regardless of Cond.
- MEM_Retired increments by 1 on each edge where the IR opcode is non-zero. It wraps at 2^CNT_W.
- Reset (asynchronous, any time, including mid-sequence): all MEM_WB_* outputs are 0, MEM_Retired is 0, and every memory word is 0. An in-flight SW at the reset edge is discarded.

## Timing
- Latency is 1 cycle from EX_MEM_* inputs to MEM_WB_* outputs. The branch outputs have 0-cycle (combinational) latency.
- Stores commit at the edge. An LW in the next cycle to the same index returns the stored value; there is no same-edge hazard because only one instruction occupies the stage.
- dbg_data reflects a store from the cycle after its commit edge.
- No stall or handshake: the stage accepts a new instruction every cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An LW/SW with EX_MEM_ALU_output[1:0] != 0 is suppressed: no memory write, and MEM_WB_LMD <= 0.
  - MEM_WB_Err <= 1 for that instruction and 0 otherwise; reset value 0.
  - The instruction still counts as retired.
- MEM_ALIGN_CHECK_EN undefined: the MEM_WB_Err port is absent, bits [1:0] are ignored, and all accesses proceed.

## Structure
- Shared package pipe_pkg: opcode localparams (OP_NOP, OP_LW, OP_SW, OP_BRANCH, OP_J, ALU range) and the opcode-field slice bounds, shared with the decode and execute stages.
- One sub-module, data_mem: a 2^ADDR_W x 32 array with async clear, synchronous write, one synchronous read port and one combinational debug port.
- Opcode decode and the counter stay in mem_access.

## Test plan
- Reset: assert rst mid-run after several stores -> all outputs 0, MEM_Retired 0, dbg_data 0 at every probed index.
- Store then load: SW with ALU_output=8, B=32'hDEADBEEF; then LW with ALU_output=8 -> MEM_WB_LMD = 32'hDEADBEEF one cycle after the LW; dbg_addr=2 reads 32'hDEADBEEF.
- Wrap-around: SW with ALU_output=32'h0000_0404, B=7 (ADDR_W=8) -> dbg_addr=1 reads 7.
- Branch: BRANCH with Cond=1, ALU_output=0x40 -> taken=1, target=0x40 in the same cycle. With Cond=0 -> taken=0. J with Cond=0 -> taken=1. ALU op with Cond=1 -> taken=0.
- Counter: sequence NOP, ALU, LW, NOP, SW -> MEM_Retired = 3. MEM_WB_IR trails the input by exactly one cycle throughout.
- Misaligned (with MEM_ALIGN_CHECK_EN): SW with ALU_output=5, B=9 -> memory unchanged and MEM_WB_Err=1 for one cycle. Without the macro, the same stimulus writes 9 to index 1.
